// File: rtl/butterfly_pkg.sv
// Shared types and constants for the ButterFly instruction prefetcher.
package butterfly_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    PF_RUN,
    PF_FLUSH
  } pf_state_e;

endpackage

// File: rtl/butterfly_sync_fifo.sv
// Small synchronous FIFO with a clear input; the head entry is readable
// combinationally so a pushed entry is visible the cycle after the push.
module butterfly_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/butterfly_prefetch.sv
// Sequential instruction prefetcher with redirect flush and in-flight drop.
// Optional statistics counters are enabled by defining BUTTERFLY_PREFETCH_STATS_EN.
module butterfly_prefetch
  import butterfly_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
`ifdef BUTTERFLY_PREFETCH_STATS_EN
  ,
  output logic [31:0] stat_redirects_o,
  output logic [31:0] stat_starve_o,
  output logic [31:0] stat_dropped_o
`endif
);

  localparam int FW = $clog2(DEPTH) + 1;
  // One spare bit: a grant racing a redirect can leave DEPTH+1 responses owed.
  localparam int CW = $clog2(DEPTH) + 2;

  pf_state_e    state_reg, state_next;
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] drop_cnt_reg, drop_cnt_next;
  logic [FW-1:0] fifo_count, tag_count;
  logic [31:0]  tag_head;
  fetch_entry_t head_entry, push_entry;
  logic         grant, keep, pop, instr_valid;
  logic         unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];

  assign mem_req_o  = !rst_i && !redirect_i &&
                      ((CW'(fifo_count) + outstanding_reg) < CW'(DEPTH));
  assign mem_addr_o = fetch_pc_reg;
  assign grant      = mem_req_o && mem_gnt_i;
  assign keep       = mem_rvalid_i && !redirect_i && (state_reg == PF_RUN) && (tag_count != '0);
  assign instr_valid = (fifo_count != '0);
  assign pop        = instr_valid && instr_ready_i && !redirect_i;
  assign push_entry = '{instr: mem_rdata_i, pc: tag_head};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= PF_RUN;
      fetch_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    outstanding_next = outstanding_reg;
    drop_cnt_next    = drop_cnt_reg;
    if (redirect_i) begin
      // Everything still owed by memory, including a grant racing the redirect, is stale.
      drop_cnt_next    = outstanding_reg + CW'(mem_gnt_i) - CW'(mem_rvalid_i);
      outstanding_next = drop_cnt_next;
      fetch_pc_next    = {redirect_pc_i[31:2], 2'b00};
      state_next       = (drop_cnt_next != '0) ? PF_FLUSH : PF_RUN;
    end else begin
      outstanding_next = outstanding_reg + CW'(grant) - CW'(mem_rvalid_i);
      if (grant) fetch_pc_next = fetch_pc_reg + 32'd4;
      if (state_reg == PF_FLUSH && mem_rvalid_i) begin
        drop_cnt_next = drop_cnt_reg - CW'(1);
        if (drop_cnt_next == '0) state_next = PF_RUN;
      end
    end
  end

  butterfly_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (redirect_i),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (fifo_count)
  );

  butterfly_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (redirect_i),
    .push      (grant),
    .push_data (fetch_pc_reg),
    .pop       (keep),
    .head      (tag_head),
    .count     (tag_count)
  );

  assign instr_valid_o = instr_valid;
  assign instr_o       = instr_valid ? head_entry.instr : 32'h0;
  assign instr_pc_o    = instr_valid ? head_entry.pc    : 32'h0;

`ifdef BUTTERFLY_PREFETCH_STATS_EN
  logic [2:0] stat_inc;
  assign stat_inc = {mem_rvalid_i && !keep, instr_ready_i && !instr_valid, redirect_i};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [31:0] cnt_reg;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                 cnt_reg <= '0;
      else if (stat_inc[gi] && cnt_reg != '1)    cnt_reg <= cnt_reg + 32'd1;
    end
  end

  assign stat_redirects_o = g_stat[0].cnt_reg;
  assign stat_starve_o    = g_stat[1].cnt_reg;
  assign stat_dropped_o   = g_stat[2].cnt_reg;
`endif

endmodule

// File: tb/tb_butterfly_prefetch.sv
// Randomized scoreboard bench for butterfly_prefetch with an epoch-based memory model.
module tb_butterfly_prefetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i, redirect_i, instr_ready_i, mem_gnt_i, mem_rvalid_i;
  logic [31:0] redirect_pc_i, mem_rdata_i;
  logic        instr_valid_o, mem_req_o;
  logic [31:0] instr_o, instr_pc_o, mem_addr_o;
`ifdef BUTTERFLY_PREFETCH_STATS_EN
  logic [31:0] stat_redirects_o, stat_starve_o, stat_dropped_o;
`endif

  always #5 clk = ~clk;

  butterfly_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
`ifdef BUTTERFLY_PREFETCH_STATS_EN
    ,
    .stat_redirects_o (stat_redirects_o),
    .stat_starve_o    (stat_starve_o),
    .stat_dropped_o   (stat_dropped_o)
`endif
  );

  // A fetch belongs to the epoch current when memory accepted it; a redirect
  // opens a new epoch and every older response is worthless.
  typedef struct {logic [31:0] data; int epoch;} pend_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} exp_t;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  int          p_gnt, p_rv, p_rdy, p_redir;
  bit          force_redir;
  logic [31:0] force_pc;
  logic [31:0] model_pc;
  int          epoch, fifo_m, cyc, grants, first_grant, first_valid;
  int          m_redirects, m_starve, m_dropped;
  bit          cap_pop;
  logic [31:0] first_pop_pc;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    exp_q.delete();
    model_pc    = RESET_PC;
    epoch       = 0;
    fifo_m      = 0;
    m_redirects = 0;
    m_starve    = 0;
    m_dropped   = 0;
  endtask

  task automatic idle_inputs();
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = 32'h0;
  endtask

  task automatic set_knobs(int g, int rv, int rdy, int rd);
    p_gnt = g; p_rv = rv; p_rdy = rdy; p_redir = rd;
  endtask

  // One bus cycle: drive memory and core inputs, then update the model.
  task automatic cycle();
    pend_t       rsp;
    int          outst;
    logic        exp_req;
    logic [31:0] d;
    @(negedge clk);
    cyc++;
    outst = pend_q.size();
    rsp = '{data: 32'h0, epoch: -1};
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    if (outst > 0 && int'($urandom_range(99)) < p_rv) begin
      rsp          = pend_q.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rsp.data;
    end
    mem_gnt_i     = int'($urandom_range(99)) < p_gnt;
    instr_ready_i = int'($urandom_range(99)) < p_rdy;
    redirect_i    = force_redir || (int'($urandom_range(99)) < p_redir);
    redirect_pc_i = force_redir ? force_pc : $urandom;
    force_redir   = 1'b0;
    #1;
    exp_req = !redirect_i && (fifo_m + outst < DEPTH);
    check("mem_req", 32'(mem_req_o), 32'(exp_req));
    check("instr_valid", 32'(instr_valid_o), 32'(fifo_m > 0));
    if (instr_ready_i && !instr_valid_o) m_starve++;
    if (instr_valid_o && first_valid < 0) first_valid = cyc;
    d = $urandom;
    if (redirect_i) begin
      m_redirects++;
      if (mem_gnt_i) pend_q.push_back('{data: d, epoch: epoch});
    end else if (mem_req_o && mem_gnt_i) begin
      check("mem_addr", mem_addr_o, model_pc);
      pend_q.push_back('{data: d, epoch: epoch});
      exp_q.push_back('{instr: d, pc: model_pc});
      model_pc = model_pc + 32'd4;
      grants++;
      if (first_grant < 0) first_grant = cyc;
    end
    if (mem_rvalid_i) begin
      if (!redirect_i && rsp.epoch == epoch) fifo_m++;
      else m_dropped++;
    end
    if (instr_valid_o && instr_ready_i && !redirect_i && fifo_m > 0) fifo_m--;
    if (redirect_i) begin
      epoch++;
      fifo_m = 0;
      exp_q.delete();
      model_pc = {redirect_pc_i[31:2], 2'b00};
    end
  endtask

  // Scoreboard monitor: every instruction the core accepts must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_i && instr_valid_o && instr_ready_i && !redirect_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got pc %h expected no instruction", instr_pc_o);
      end else begin
        e = exp_q.pop_front();
        check("instr", instr_o, e.instr);
        check("instr_pc", instr_pc_o, e.pc);
        if (cap_pop) begin
          first_pop_pc = instr_pc_o;
          cap_pop      = 1'b0;
        end
      end
    end
  end

  task automatic drain();
    set_knobs(0, 100, 100, 0);
    repeat (10) cycle();
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    set_knobs(0, 0, 0, 0);
    force_redir = 1'b0;
    force_pc    = 32'h0;
    cap_pop     = 1'b0;
    first_pop_pc = 32'h0;
    cyc = 0;
    model_reset();
    #1;
    check("rst_valid", 32'(instr_valid_o), 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", instr_pc_o, 32'h0);
    check("rst_req", 32'(mem_req_o), 32'h0);
    check("rst_addr", mem_addr_o, RESET_PC);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    // Streaming: first instruction two cycles after the first grant.
    set_knobs(100, 100, 100, 0);
    first_grant = -1;
    first_valid = -1;
    repeat (12) cycle();
    check("first_valid_latency", 32'(first_valid - first_grant), 32'd2);

    // Back-pressure: exactly DEPTH grants, then one more per freed slot.
    drain();
    set_knobs(100, 100, 0, 0);
    grants = 0;
    repeat (10) cycle();
    check("grants_full", 32'(grants), 32'(DEPTH));
    grants = 0;
    p_rdy = 100;
    cycle();
    p_rdy = 0;
    repeat (6) cycle();
    check("grants_one_slot", 32'(grants), 32'd1);

    // Redirect with three fetches in flight; their responses must vanish.
    drain();
    set_knobs(100, 0, 100, 0);
    repeat (3) cycle();
    set_knobs(0, 0, 100, 0);
    force_redir = 1'b1;
    force_pc    = 32'h0000_0102;
    cycle();
    @(posedge clk);
    #1;
    check("redirect_addr", mem_addr_o, 32'h0000_0100);
    cap_pop = 1'b1;
    set_knobs(100, 100, 100, 0);
    repeat (14) cycle();
    check("first_pop_after_redirect", first_pop_pc, 32'h0000_0100);

    // Redirect racing a grant and a response with two fetches in flight.
    drain();
    set_knobs(100, 0, 100, 0);
    repeat (2) cycle();
    set_knobs(100, 100, 100, 0);
    force_redir = 1'b1;
    force_pc    = 32'h0000_2000;
    cycle();
    repeat (14) cycle();

    // Address wrap from the top of the address space.
    drain();
    set_knobs(100, 100, 100, 0);
    force_redir = 1'b1;
    force_pc    = 32'hFFFF_FFFC;
    cycle();
    @(posedge clk);
    #1;
    check("wrap_start_addr", mem_addr_o, 32'hFFFF_FFFC);
    cycle();
    @(posedge clk);
    #1;
    check("wrap_next_addr", mem_addr_o, 32'h0000_0000);
    repeat (6) cycle();

    // Asynchronous reset in the middle of a burst.
    set_knobs(100, 70, 50, 0);
    repeat (10) cycle();
    @(negedge clk);
    idle_inputs();
    #3;
    rst_i = 1'b1;
    #1;
    check("async_rst_valid", 32'(instr_valid_o), 32'h0);
    check("async_rst_addr", mem_addr_o, RESET_PC);
    check("async_rst_req", 32'(mem_req_o), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    // Randomized traffic with varying pressure and occasional redirects.
    for (int blk = 0; blk < 15; blk++) begin
      set_knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                int'($urandom_range(100, 20)), int'($urandom_range(10, 0)));
      repeat (200) cycle();
    end

`ifdef BUTTERFLY_PREFETCH_STATS_EN
    @(posedge clk);
    #1;
    check("stat_redirects", stat_redirects_o, 32'(m_redirects));
    check("stat_starve", stat_starve_o, 32'(m_starve));
    check("stat_dropped", stat_dropped_o, 32'(m_dropped));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
